// File: rtl/fighter_pkg.sv
// Shared action codes, controller bit positions and decode helpers for the
// per-player fighter action sequencer.
package fighter_pkg;

    typedef enum logic [3:0] {
        ACT_IDLE    = 4'd0,
        ACT_WALK_L  = 4'd1,
        ACT_WALK_R  = 4'd2,
        ACT_JUMP    = 4'd3,
        ACT_CROUCH  = 4'd4,
        ACT_WINDUP  = 4'd5,
        ACT_ACTIVE  = 4'd6,
        ACT_RECOVER = 4'd7,
        ACT_SHIELD  = 4'd8
    } action_t;

    localparam int unsigned BTN_CENTER = 0;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_RIGHT  = 2;
    localparam int unsigned BTN_UP     = 3;
    localparam int unsigned BTN_DOWN   = 4;
    localparam int unsigned BTN_ATTACK = 5;
    localparam int unsigned BTN_SHIELD = 6;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Only a single pressed direction is meaningful; anything else reads as center.
    function automatic action_t decode_dir(input logic [4:0] dir);
        case (dir)
            5'b00010: return ACT_WALK_L;
            5'b00100: return ACT_WALK_R;
            5'b01000: return ACT_JUMP;
            5'b10000: return ACT_CROUCH;
            default:  return ACT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fighter_action_fsm_button_debounce.sv
// Tick-based button debouncer: the level flips only after the raw input has
// disagreed with it for DEBOUNCE_TICKS consecutive ticks.
module button_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level
);
    localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_TICKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (tick) begin
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_END) begin
                level <= raw;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fighter_action_fsm.sv
// Per-player action sequencer: debounced attack/shield, timed attack phases
// with a one-deep attack buffer, and a shield with duration cap and cooldown.
module fighter_action_fsm
    import fighter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS        = 4,
    parameter int unsigned WINDUP_TICKS          = 3,
    parameter int unsigned ACTIVE_TICKS          = 4,
    parameter int unsigned RECOVER_TICKS         = 6,
    parameter int unsigned SHIELD_MAX_TICKS      = 32,
    parameter int unsigned SHIELD_COOLDOWN_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [6:0] ctrl_state,
    output logic [3:0] action,
    output logic       hit_active,
    output logic       shield_active,
    output logic       busy,
    output logic       shield_ready
);
    localparam int unsigned DUR_MAX = max4(WINDUP_TICKS, ACTIVE_TICKS, RECOVER_TICKS, SHIELD_MAX_TICKS);
    localparam int unsigned DUR_W   = $clog2(DUR_MAX + 1);
    localparam int unsigned COOL_W  = $clog2(SHIELD_COOLDOWN_TICKS + 1);

    localparam logic [DUR_W-1:0]  WINDUP_END  = DUR_W'(WINDUP_TICKS - 1);
    localparam logic [DUR_W-1:0]  ACTIVE_END  = DUR_W'(ACTIVE_TICKS - 1);
    localparam logic [DUR_W-1:0]  RECOVER_END = DUR_W'(RECOVER_TICKS - 1);
    localparam logic [DUR_W-1:0]  SHIELD_END  = DUR_W'(SHIELD_MAX_TICKS - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD   = COOL_W'(SHIELD_COOLDOWN_TICKS);

    action_t           state, state_nxt, dir_act, move_nxt;
    logic [DUR_W-1:0]  dur, dur_nxt;
    logic [COOL_W-1:0] cool, cool_nxt;
    logic              pending, pending_nxt;
    logic              attack_lvl, shield_lvl, attack_prev, attack_edge;

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_attack_db (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (ctrl_state[BTN_ATTACK]),
        .level (attack_lvl)
    );

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_shield_db (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (ctrl_state[BTN_SHIELD]),
        .level (shield_lvl)
    );

    always_comb begin
        attack_edge = attack_lvl & ~attack_prev;
        dir_act     = decode_dir(ctrl_state[BTN_DOWN:BTN_CENTER]);
        if (shield_lvl && cool == '0)
            move_nxt = ACT_SHIELD;
        else if (attack_edge)
            move_nxt = ACT_WINDUP;
        else
            move_nxt = dir_act;
    end

    // Timed states count up from 0 and leave when the count reaches N-1.
    always_comb begin
        state_nxt   = state;
        dur_nxt     = '0;
        pending_nxt = 1'b0;
        cool_nxt    = (cool != '0) ? cool - 1'b1 : '0;
        unique case (state)
            ACT_WINDUP:
                if (dur >= WINDUP_END) state_nxt = ACT_ACTIVE;
                else                   dur_nxt   = dur + 1'b1;
            ACT_ACTIVE:
                if (dur >= ACTIVE_END) state_nxt = ACT_RECOVER;
                else                   dur_nxt   = dur + 1'b1;
            ACT_RECOVER:
                if (dur >= RECOVER_END) begin
                    state_nxt = (pending || attack_edge) ? ACT_WINDUP : move_nxt;
                end else begin
                    dur_nxt     = dur + 1'b1;
                    pending_nxt = pending | attack_edge;
                end
            ACT_SHIELD:
                if (!shield_lvl || dur >= SHIELD_END) begin
                    cool_nxt  = COOL_LOAD;
                    state_nxt = attack_edge ? ACT_WINDUP : dir_act;
                end else begin
                    dur_nxt = dur + 1'b1;
                end
            default:
                state_nxt = move_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ACT_IDLE;
            dur           <= '0;
            cool          <= '0;
            pending       <= 1'b0;
            attack_prev   <= 1'b0;
            hit_active    <= 1'b0;
            shield_active <= 1'b0;
            busy          <= 1'b0;
            shield_ready  <= 1'b1;
        end else if (tick) begin
            state         <= state_nxt;
            dur           <= dur_nxt;
            cool          <= cool_nxt;
            pending       <= pending_nxt;
            attack_prev   <= attack_lvl;
            hit_active    <= (state_nxt == ACT_ACTIVE);
            shield_active <= (state_nxt == ACT_SHIELD);
            busy          <= (state_nxt inside {ACT_WINDUP, ACT_ACTIVE, ACT_RECOVER});
            shield_ready  <= (cool_nxt == '0);
        end
    end

    assign action = state;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Bench for fighter_action_fsm: two instances (slow and fast debounce) share
// stimulus and are compared every cycle against a tick-level behavioural model.
module tb_fighter_action_fsm;
    localparam int W    = 2;
    localparam int A    = 3;
    localparam int R    = 2;
    localparam int SMAX = 8;
    localparam int COOL = 5;
    localparam int D0   = 4;
    localparam int D1   = 2;

    localparam logic [6:0] CEN = 7'b0000001;
    localparam logic [6:0] ATK = 7'b0100001;
    localparam logic [6:0] SHD = 7'b1000001;

    logic       clk = 1'b0;
    logic       reset, tick;
    logic [6:0] ctrl_state;
    logic [3:0] action0, action1;
    logic       hit0, hit1, sh0, sh1, busy0, busy1, rdy0, rdy1;

    int checks = 0;
    int errors = 0;

    // Model state per instance: debounced levels, mismatch run lengths,
    // previous attack level, current action, ticks left, cooldown, pending.
    int m_la[2], m_ls[2], m_ra[2], m_rs[2], m_prev[2];
    int m_act[2], m_left[2], m_cd[2], m_pend[2];

    always #5 clk = ~clk;

    fighter_action_fsm #(
        .DEBOUNCE_TICKS(D0), .WINDUP_TICKS(W), .ACTIVE_TICKS(A), .RECOVER_TICKS(R),
        .SHIELD_MAX_TICKS(SMAX), .SHIELD_COOLDOWN_TICKS(COOL)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .ctrl_state(ctrl_state),
        .action(action0), .hit_active(hit0), .shield_active(sh0),
        .busy(busy0), .shield_ready(rdy0)
    );

    fighter_action_fsm #(
        .DEBOUNCE_TICKS(D1), .WINDUP_TICKS(W), .ACTIVE_TICKS(A), .RECOVER_TICKS(R),
        .SHIELD_MAX_TICKS(SMAX), .SHIELD_COOLDOWN_TICKS(COOL)
    ) dut_fast (
        .clk(clk), .reset(reset), .tick(tick), .ctrl_state(ctrl_state),
        .action(action1), .hit_active(hit1), .shield_active(sh1),
        .busy(busy1), .shield_ready(rdy1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dir_of(input logic [6:0] c);
        if ($countones(c[4:0]) != 1) return 0;
        if (c[1]) return 1;
        if (c[2]) return 2;
        if (c[3]) return 3;
        if (c[4]) return 4;
        return 0;
    endfunction

    function automatic int len_of(input int code);
        case (code)
            5: return W;
            6: return A;
            7: return R;
            8: return SMAX;
            default: return 0;
        endcase
    endfunction

    task automatic enter(input int k, input int code);
        m_act[k]  = code;
        m_left[k] = len_of(code);
    endtask

    task automatic model_reset(input int k);
        m_la[k] = 0; m_ls[k] = 0; m_ra[k] = 0; m_rs[k] = 0; m_prev[k] = 0;
        m_act[k] = 0; m_left[k] = 0; m_cd[k] = 0; m_pend[k] = 0;
    endtask

    task automatic model_tick(input int k, input logic [6:0] c);
        int att, shd, edg, mv, cd_n, d;
        d    = (k == 0) ? D0 : D1;
        att  = m_la[k];
        shd  = m_ls[k];
        edg  = (att == 1 && m_prev[k] == 0) ? 1 : 0;
        mv   = (shd == 1 && m_cd[k] == 0) ? 8 : (edg == 1 ? 5 : dir_of(c));
        cd_n = (m_cd[k] > 0) ? m_cd[k] - 1 : 0;
        case (m_act[k])
            5, 6, 7: begin
                if (m_act[k] == 7 && edg == 1) m_pend[k] = 1;
                m_left[k]--;
                if (m_left[k] == 0) begin
                    if (m_act[k] == 5)      enter(k, 6);
                    else if (m_act[k] == 6) enter(k, 7);
                    else begin
                        enter(k, (m_pend[k] == 1) ? 5 : mv);
                        m_pend[k] = 0;
                    end
                end
            end
            8: begin
                m_left[k]--;
                if (shd == 0 || m_left[k] == 0) begin
                    cd_n = COOL;
                    enter(k, (edg == 1) ? 5 : dir_of(c));
                end
            end
            default: enter(k, mv);
        endcase
        m_cd[k]   = cd_n;
        m_prev[k] = att;
        if (int'(c[5]) != m_la[k]) begin
            m_ra[k]++;
            if (m_ra[k] >= d) begin m_la[k] = int'(c[5]); m_ra[k] = 0; end
        end else m_ra[k] = 0;
        if (int'(c[6]) != m_ls[k]) begin
            m_rs[k]++;
            if (m_rs[k] >= d) begin m_ls[k] = int'(c[6]); m_rs[k] = 0; end
        end else m_rs[k] = 0;
    endtask

    task automatic compare_all();
        chk("act0",  8'(action0), 8'(m_act[0]));
        chk("hit0",  8'(hit0),    8'(m_act[0] == 6));
        chk("sh0",   8'(sh0),     8'(m_act[0] == 8));
        chk("busy0", 8'(busy0),   8'(m_act[0] >= 5 && m_act[0] <= 7));
        chk("rdy0",  8'(rdy0),    8'(m_cd[0] == 0));
        chk("act1",  8'(action1), 8'(m_act[1]));
        chk("hit1",  8'(hit1),    8'(m_act[1] == 6));
        chk("sh1",   8'(sh1),     8'(m_act[1] == 8));
        chk("busy1", 8'(busy1),   8'(m_act[1] >= 5 && m_act[1] <= 7));
        chk("rdy1",  8'(rdy1),    8'(m_cd[1] == 0));
    endtask

    task automatic step(input logic tk, input logic rst, input logic [6:0] c);
        tick       = tk;
        reset      = rst;
        ctrl_state = c;
        for (int k = 0; k < 2; k++) begin
            if (rst) model_reset(k);
            else if (tk) model_tick(k, c);
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, CEN);
    endtask

    initial begin
        int         busy_cnt, hit_cnt, e;
        logic [6:0] rc;
        logic [6:0] c;
        reset = 1'b1; tick = 1'b1; ctrl_state = CEN;

        step(1'b1, 1'b1, CEN);
        step(1'b0, 1'b1, CEN);
        chk("reset_act", 8'(action0), 8'd0);
        chk("reset_rdy", 8'(rdy0), 8'd1);

        step(1'b1, 1'b0, 7'b0000010); chk("dir_left",  8'(action0), 8'd1);
        step(1'b1, 1'b0, 7'b0000110); chk("dir_multi", 8'(action0), 8'd0);
        step(1'b1, 1'b0, 7'b0010000); chk("dir_down",  8'(action0), 8'd4);
        settle(2);

        busy_cnt = 0; hit_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, ATK);
            e = (i <= 4) ? 0 : (i <= 6) ? 5 : (i <= 9) ? 6 : (i <= 11) ? 7 : 0;
            chk("atk_seq", 8'(action0), 8'(e));
            if (busy0) busy_cnt++;
            if (hit0) hit_cnt++;
        end
        chk("atk_busy_len", 8'(busy_cnt), 8'd7);
        chk("atk_hit_len", 8'(hit_cnt), 8'd3);
        settle(16);

        for (int i = 1; i <= 15; i++) begin
            step(1'b1, 1'b0, (i <= 3) ? ATK : CEN);
            chk("glitch_act", 8'(action0), 8'd0);
            chk("glitch_busy", 8'(busy0), 8'd0);
        end

        for (int i = 1; i <= 18; i++) begin
            step(1'b1, 1'b0, (i <= 2 || i >= 7) ? ATK : CEN);
            e = (i <= 2) ? 0 : (i <= 4) ? 5 : (i <= 7) ? 6 : (i <= 9) ? 7 :
                (i <= 11) ? 5 : (i <= 14) ? 6 : (i <= 16) ? 7 : 0;
            chk("buf_seq", 8'(action1), 8'(e));
        end
        settle(24);

        for (int i = 1; i <= 14; i++) begin
            step(1'b1, 1'b0, (i <= 2 || i >= 5) ? ATK : CEN);
            e = (i <= 2) ? 0 : (i <= 4) ? 5 : (i <= 7) ? 6 : (i <= 9) ? 7 : 0;
            chk("drop_seq", 8'(action1), 8'(e));
        end
        settle(24);

        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, SHD);
            e = (i <= 4) ? 0 : (i <= 12) ? 8 : (i <= 18) ? 0 : 8;
            chk("shield_act", 8'(action0), 8'(e));
            chk("shield_rdy", 8'(rdy0), 8'((i <= 12 || i >= 18) ? 1 : 0));
        end
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b0, (i <= 2) ? CEN : ATK);
            if (i == 5) begin
                chk("shield_exit_act", 8'(action0), 8'd0);
                chk("shield_exit_rdy", 8'(rdy0), 8'd0);
            end
        end
        chk("cooldown_atk_act", 8'(action0), 8'd5);
        chk("cooldown_atk_rdy", 8'(rdy0), 8'd0);
        settle(24);

        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, ATK);
        for (int i = 0; i < 10; i++) begin
            c = 7'($urandom);
            step(1'b0, 1'b0, c);
            chk("freeze_act",  8'(action0), 8'd6);
            chk("freeze_hit",  8'(hit0),    8'd1);
            chk("freeze_busy", 8'(busy0),   8'd1);
            chk("freeze_rdy",  8'(rdy0),    8'd1);
            chk("freeze_sh",   8'(sh0),     8'd0);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, ATK);
        settle(24);

        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, ATK);
        chk("pre_reset_act", 8'(action0), 8'd6);
        step(1'b1, 1'b1, CEN);
        chk("rst_act",  8'(action0), 8'd0);
        chk("rst_hit",  8'(hit0),    8'd0);
        chk("rst_busy", 8'(busy0),   8'd0);
        chk("rst_rdy",  8'(rdy0),    8'd1);
        settle(24);

        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, (i <= 2 || i >= 7) ? ATK : CEN);
        chk("pend_pre_act", 8'(action1), 8'd7);
        step(1'b1, 1'b1, CEN);
        chk("pend_rst_act", 8'(action1), 8'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, CEN);
            chk("pend_cleared_act", 8'(action1), 8'd0);
            chk("pend_cleared_busy", 8'(busy1), 8'd0);
        end

        rc = CEN;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 7) == 0) rc[5] = ~rc[5];
            if ($urandom_range(0, 9) == 0) rc[6] = ~rc[6];
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 7))
                    0: rc[4:0] = 5'b00001;
                    1: rc[4:0] = 5'b00010;
                    2: rc[4:0] = 5'b00100;
                    3: rc[4:0] = 5'b01000;
                    4: rc[4:0] = 5'b10000;
                    5: rc[4:0] = 5'b00000;
                    default: rc[4:0] = 5'($urandom);
                endcase
            end
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 299) == 0), rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
